shift4_deser: RTL and testbench

//  Serial-in/parallel-out receiver. Rebuilds size-bit words from the LSB-first bit stream

---
 rtl/shift4_deser_if.sv | 24 ++
 rtl/shift4_deser.sv | 66 ++++++
 tb/tb_shift4_deser.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/shift4_deser_if.sv
// rtl/shift4_deser_if.sv - serial input and one-entry valid/ready output bundle for shift4_deser
interface shift4_deser_if #(
  parameter int size = 4
);
  logic            ena;
  logic            din;
  logic            align;
  logic            q_ready;
  logic            clr_ovr;
  logic [size-1:0] q;
  logic            q_valid;
  logic            overrun;
  logic            busy;

  modport master (
    output ena, din, align, q_ready, clr_ovr,
    input  q, q_valid, overrun, busy
  );

  modport slave (
    input  ena, din, align, q_ready, clr_ovr,
    output q, q_valid, overrun, busy
  );
endinterface

// File: rtl/shift4_deser.sv
// rtl/shift4_deser.sv - LSB-first serial-to-parallel receiver with one-entry output register
module shift4_deser #(
  parameter int size = 4
) (
  input  logic          clk,
  input  logic          areset,
  shift4_deser_if.slave bus
);
  localparam int CNT_W = $clog2(size);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(size - 1);

  logic [size-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [size-1:0]  word;
  logic             complete;
  logic             accept;
  logic             dropped;

  // din only enters the datapath when ena is high, so an undriven din cannot leak in
  assign word     = {bus.din, sr[size-1:1]};
  assign complete = bus.ena & ~bus.align & (cnt == LAST);
  assign accept   = complete & (~bus.q_valid | bus.q_ready);
  assign dropped  = complete & bus.q_valid & ~bus.q_ready;
  assign bus.busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (areset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.align) begin
      if (bus.ena) begin
        sr  <= {bus.din, {(size-1){1'b0}}};
        cnt <= CNT_W'(1);
      end else begin
        sr  <= '0;
        cnt <= '0;
      end
    end else if (bus.ena) begin
      sr  <= word;
      cnt <= complete ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
    end else if (accept) begin
      bus.q       <= word;
      bus.q_valid <= 1'b1;
    end else if (bus.q_valid && bus.q_ready) begin
      bus.q_valid <= 1'b0;
    end
  end

  // a drop on the same edge as clr_ovr leaves the flag set
  always_ff @(posedge clk) begin
    if (areset) begin
      bus.overrun <= 1'b0;
    end else if (dropped) begin
      bus.overrun <= 1'b1;
    end else if (bus.clr_ovr) begin
      bus.overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift4_deser.sv
// tb/tb_shift4_deser.sv - randomized and directed checks of shift4_deser against a bit-queue model
module tb_shift4_deser;
  logic clk = 1'b0;
  logic areset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift4_deser_if #(.size(4)) bus ();

  shift4_deser #(.size(4)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  bit         bits[$];
  logic [3:0] m_q;
  logic       m_v;
  logic       m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic a, input logic r,
                      input logic c, input logic rs);
    logic [3:0] w;
    bit         done;
    bus.ena = e; bus.din = d; bus.align = a; bus.q_ready = r; bus.clr_ovr = c; areset = rs;
    @(posedge clk);
    done = 1'b0;
    w = '0;
    if (rs) begin
      bits.delete();
      m_q = '0; m_v = 1'b0; m_ovr = 1'b0;
    end else begin
      if (a) begin
        bits.delete();
        if (e) bits.push_back(d);
      end else if (e) begin
        bits.push_back(d);
        if (bits.size() == 4) begin
          for (int i = 0; i < 4; i++) w[i] = bits[i];
          bits.delete();
          done = 1'b1;
        end
      end
      if (done && (!m_v || r)) begin
        m_q = w; m_v = 1'b1;
        if (c) m_ovr = 1'b0;
      end else if (done) begin
        m_ovr = 1'b1;
      end else begin
        if (m_v && r) m_v = 1'b0;
        if (c) m_ovr = 1'b0;
      end
    end
    #1;
    check("model_q", 32'(bus.q), 32'(m_q));
    check("model_q_valid", 32'(bus.q_valid), 32'(m_v));
    check("model_overrun", 32'(bus.overrun), 32'(m_ovr));
    check("model_busy", 32'(bus.busy), 32'(bits.size() != 0));
  endtask

  task automatic send(input logic [3:0] w, input logic r, input bit gaps, input logic clr_last);
    for (int i = 0; i < 4; i++) begin
      if (gaps) step(1'b0, 1'bx, 1'b0, r, 1'b0, 1'b0);
      step(1'b1, w[i], 1'b0, r, (i == 3) ? clr_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset with random serial activity
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_q", 32'(bus.q), 32'h0);
    check("reset_q_valid", 32'(bus.q_valid), 32'h0);
    check("reset_overrun", 32'(bus.overrun), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);

    // basic word, held under back-pressure then consumed
    send(4'b1101, 1'b0, 1'b0, 1'b0);
    check("basic_q", 32'(bus.q), 32'hd);
    check("basic_q_valid", 32'(bus.q_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("basic_consumed_valid", 32'(bus.q_valid), 32'h0);
    check("basic_consumed_q", 32'(bus.q), 32'hd);

    // gapped stream with busy tracking across the wrap
    begin
      logic [3:0] g;
      g = 4'b1110;
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'bx, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, g[i], 1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_busy", 32'(bus.busy), (i < 3) ? 32'h1 : 32'h0);
      end
      check("gap_q", 32'(bus.q), 32'he);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // overrun set, cleared, and set winning over clear
    send(4'hA, 1'b0, 1'b0, 1'b0);
    send(4'h5, 1'b0, 1'b0, 1'b0);
    check("ovr_q", 32'(bus.q), 32'ha);
    check("ovr_q_valid", 32'(bus.q_valid), 32'h1);
    check("ovr_flag", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_cleared", 32'(bus.overrun), 32'h0);
    send(4'h7, 1'b0, 1'b0, 1'b1);
    check("ovr_set_wins", 32'(bus.overrun), 32'h1);
    check("ovr_q_hold", 32'(bus.q), 32'ha);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // back-to-back with a consumer always ready
    send(4'h3, 1'b1, 1'b0, 1'b0);
    check("b2b_first_q", 32'(bus.q), 32'h3);
    check("b2b_first_valid", 32'(bus.q_valid), 32'h1);
    send(4'hC, 1'b1, 1'b0, 1'b0);
    check("b2b_second_q", 32'(bus.q), 32'hc);
    check("b2b_second_valid", 32'(bus.q_valid), 32'h1);
    check("b2b_overrun", 32'(bus.overrun), 32'h0);

    // align mid-word restarts framing on the align bit
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("align_q", 32'(bus.q), 32'h9);

    // reset mid-word discards the partial word and the reset-cycle bit
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("midreset_busy", 32'(bus.busy), 32'h0);
    send(4'b0110, 1'b0, 1'b0, 1'b0);
    check("midreset_q", 32'(bus.q), 32'h6);

    // align arriving on the would-be last bit must not complete a word
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("align_last_no_word", 32'(bus.q_valid), 32'h0);
    check("align_last_busy", 32'(bus.busy), 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic e, a;
      e = ($urandom_range(99) < 70);
      a = ($urandom_range(99) < 8);
      step(e, e ? 1'($urandom) : 1'bx, a, 1'($urandom), ($urandom_range(99) < 10),
           ($urandom_range(99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
